leaf_out_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single leaf_interface output port among
//  NUM_REQ user output streams inside one page. Each grant is locked for a

---
 rtl/leaf_out_arbiter.sv | 130 +++++++++++++
 tb/tb_leaf_out_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter
// Round-robin arbiter sharing one leaf_interface output port among NUM_REQ user
// output streams. A grant is held for a burst of up to BURST_LEN words. The
// granted stream is passed through combinationally, so the data path has zero
// latency. Choosing a new grant costs one IDLE cycle.
//
// Ports
//   clk                 clock, rising edge
//   ap_rst_n            asynchronous reset, active low
//   enable              new grants are issued only while high
//   din_user2arb        stream i data at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_user2arb        per-stream valid
//   ack_arb2user        per-stream ack, one-hot or zero
//   dout_arb2interface  muxed data to leaf_interface
//   vld_arb2interface   valid to leaf_interface
//   ack_interface2arb   ack from leaf_interface
//   src_id              index of the granted stream, 0 when idle
//   last                final word of the current burst
//   busy                high while a grant is held
module leaf_out_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_REQ_BITS = 2,
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            ap_rst_n,
  input  logic                            enable,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_REQ-1:0]              vld_user2arb,
  output logic [NUM_REQ-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
  output logic                            vld_arb2interface,
  input  logic                            ack_interface2arb,
  output logic [NUM_REQ_BITS-1:0]         src_id,
  output logic                            last,
  output logic                            busy
);

  localparam int unsigned CntBits = $clog2(BURST_LEN + 1);
  localparam logic [CntBits-1:0] CntMax = CntBits'(BURST_LEN - 1);
  localparam logic [NUM_REQ_BITS-1:0] LastIdx = NUM_REQ_BITS'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                  state_q;
  logic [NUM_REQ_BITS-1:0] grant_q;
  logic [NUM_REQ_BITS-1:0] rr_ptr_q;
  logic [CntBits-1:0]      cnt_q;

  logic                    pick_found;
  logic [NUM_REQ_BITS-1:0] pick_idx;
  logic [NUM_REQ_BITS-1:0] cand_idx;
  int unsigned             cand;
  logic                    vld_g;
  logic                    xfer;

  // First valid stream scanning rr_ptr, rr_ptr+1, ... with explicit wrap so a
  // non-power-of-2 NUM_REQ never indexes past the last stream.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = NUM_REQ_BITS'(cand);
      if (!pick_found && vld_user2arb[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Zero-latency pass-through of the granted stream; everything idles at 0.
  always_comb begin
    dout_arb2interface = '0;
    ack_arb2user       = '0;
    vld_g              = 1'b0;
    if (state_q == StGrant) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_q == NUM_REQ_BITS'(i)) begin
          dout_arb2interface = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
          vld_g              = vld_user2arb[i];
          ack_arb2user[i]    = ack_interface2arb;
        end
      end
    end
  end

  assign vld_arb2interface = vld_g;
  assign xfer              = vld_g & ack_interface2arb;
  assign busy              = (state_q == StGrant);
  assign src_id            = busy ? grant_q : '0;
  assign last              = vld_g & (cnt_q == CntMax);

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && pick_found) begin
            grant_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          // A gap in the granted stream ends the burst early, without a transfer.
          if (!vld_g || (xfer && (cnt_q == CntMax))) begin
            rr_ptr_q <= (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
            cnt_q    <= '0;
            state_q  <= StIdle;
          end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter
// Directed bench for leaf_out_arbiter with a cycle-level reference model and a
// log of every word accepted by the interface for literal burst checks.
module tb_leaf_out_arbiter;

  localparam int NR = 4;
  localparam int NB = 2;
  localparam int PB = 32;
  localparam int BL = 16;

  logic             clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [NR*PB-1:0] din = '0;
  logic [NR-1:0]    vld_in = '0;
  logic [NR-1:0]    ack_user;
  logic [PB-1:0]    dout;
  logic             vld_out;
  logic             ack_if = 1'b0;
  logic [NB-1:0]    src_id;
  logic             last;
  logic             busy;

  leaf_out_arbiter #(
    .NUM_REQ(NR), .NUM_REQ_BITS(NB), .PAYLOAD_BITS(PB), .BURST_LEN(BL)
  ) dut (
    .clk                (clk),
    .ap_rst_n           (ap_rst_n),
    .enable             (enable),
    .din_user2arb       (din),
    .vld_user2arb       (vld_in),
    .ack_arb2user       (ack_user),
    .dout_arb2interface (dout),
    .vld_arb2interface  (vld_out),
    .ack_interface2arb  (ack_if),
    .src_id             (src_id),
    .last               (last),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int avail[NR];
  int sent[NR];

  typedef struct {
    int          src;
    bit          lst;
    logic [31:0] data;
    int          cyc;
  } ent_t;
  ent_t log_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Each stream offers words i<<28 | n; data only advances after an accepted word.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      vld_in[i]          = (avail[i] > 0);
      din[i*PB +: PB]    = (32'(i) << 28) | 32'(sent[i]);
    end
  endtask

  task automatic tick();
    bit x[NR];
    @(negedge clk);
    for (int i = 0; i < NR; i++) x[i] = vld_in[i] && ack_user[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (x[i]) begin
        sent[i]++;
        avail[i]--;
      end
    end
    drive();
  endtask

  task automatic run_until(input int n, input int limit, input string name);
    int k = 0;
    while (log_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk(name, 64'(log_q.size()), 64'(n));
  endtask

  task automatic reset_dut();
    ap_rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      avail[i] = 0;
      sent[i]  = 0;
    end
    drive();
    @(posedge clk);
    #1;
    ap_rst_n = 1'b1;
    log_q.delete();
  endtask

  // Reference model: which stream holds the port, how many words it has moved,
  // and where the round-robin scan starts next.
  int m_busy = 0, m_grant = 0, m_cnt = 0, m_rr = 0;

  function automatic int pick(input int rr, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[NB'((rr + k) % NR)]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_busy <= 0; m_grant <= 0; m_cnt <= 0; m_rr <= 0;
    end else if (m_busy == 0) begin
      if (enable && pick(m_rr, vld_in) >= 0) begin
        m_busy  <= 1;
        m_grant <= pick(m_rr, vld_in);
        m_cnt   <= 0;
      end
    end else if (!vld_in[NB'(m_grant)] || (ack_if && m_cnt == BL - 1)) begin
      m_busy <= 0;
      m_rr   <= (m_grant + 1) % NR;
      m_cnt  <= 0;
    end else if (ack_if) begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [PB-1:0] e_dout;
    logic [NR-1:0] e_ack;
    logic          e_vld, e_last;
    int            e_src;
    e_dout = '0; e_ack = '0; e_vld = 1'b0; e_last = 1'b0; e_src = 0;
    if (m_busy != 0) begin
      e_dout = din[m_grant*PB +: PB];
      e_vld  = vld_in[NB'(m_grant)];
      e_ack  = ack_if ? NR'(1 << m_grant) : '0;
      e_src  = m_grant;
      e_last = e_vld && (m_cnt == BL - 1);
    end
    chk("busy", 64'(busy), 64'(m_busy != 0));
    chk("src_id", 64'(src_id), 64'(e_src));
    chk("vld_out", 64'(vld_out), 64'(e_vld));
    chk("ack_user", 64'(ack_user), 64'(e_ack));
    chk("dout", 64'(dout), 64'(e_dout));
    chk("last", 64'(last), 64'(e_last));
    if (vld_out === 1'b1 && ack_if === 1'b1)
      log_q.push_back('{src: int'(src_id), lst: last, data: dout, cyc: cyc});
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      avail[i] = 0;
      sent[i]  = 0;
    end
    ack_if = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_vld", 64'(vld_out), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_src", 64'(src_id), 0);
    chk("rst_ack", 64'(ack_user), 0);
    chk("rst_last", 64'(last), 0);

    // 1: single stream, 20 words -> 16-word burst, one idle cycle, 4 words.
    reset_dut();
    enable = 1'b1;
    avail[0] = 20;
    drive();
    run_until(20, 100, "t1_count");
    repeat (3) tick();
    chk("t1_total", 64'(log_q.size()), 20);
    chk("t1_last16", 64'(log_q[15].lst), 1);
    chk("t1_last15", 64'(log_q[14].lst), 0);
    n = 0;
    foreach (log_q[i]) n += int'(log_q[i].lst) + log_q[i].src * 100;
    chk("t1_lastcnt_src", 64'(n), 1);
    chk("t1_gap", 64'(log_q[16].cyc - log_q[15].cyc), 2);
    chk("t1_data19", 64'(log_q[19].data), 19);

    // 2: all streams valid -> grants 0,1,2,3,0 with 16 words each.
    reset_dut();
    for (int i = 0; i < NR; i++) avail[i] = 1000;
    drive();
    run_until(80, 200, "t2_count");
    chk("t2_g0", 64'(log_q[0].src), 0);
    chk("t2_g1", 64'(log_q[16].src), 1);
    chk("t2_g2", 64'(log_q[32].src), 2);
    chk("t2_g3", 64'(log_q[48].src), 3);
    chk("t2_g4", 64'(log_q[64].src), 0);
    chk("t2_gap", 64'(log_q[16].cyc - log_q[15].cyc), 2);
    chk("t2_last", 64'(log_q[63].lst), 1);
    chk("t2_data", 64'(log_q[64].data), 64'h10);

    // 3: stream 2 stops after 5 words -> stream 3 next, then wrap to 0 before 2.
    reset_dut();
    avail[2] = 5;
    avail[3] = 3;
    drive();
    run_until(8, 60, "t3_count");
    repeat (2) tick();
    avail[0] = 1;
    avail[2] = 1;
    drive();
    run_until(10, 40, "t3_count2");
    chk("t3_first", 64'(log_q[0].src), 2);
    chk("t3_fifth", 64'(log_q[4].src), 2);
    chk("t3_next", 64'(log_q[5].src), 3);
    chk("t3_ndata", 64'(log_q[5].data), 64'h3000_0000);
    chk("t3_gap", 64'(log_q[5].cyc - log_q[4].cyc), 3);
    chk("t3_wrap", 64'(log_q[8].src), 0);
    chk("t3_after", 64'(log_q[9].src), 2);

    // 4: back-pressure holds the grant without losing data.
    reset_dut();
    ack_if = 1'b0;
    avail[1] = 4;
    drive();
    repeat (12) tick();
    chk("t4_busy", 64'(busy), 1);
    chk("t4_src", 64'(src_id), 1);
    chk("t4_ack", 64'(ack_user), 0);
    chk("t4_vld", 64'(vld_out), 1);
    chk("t4_none", 64'(log_q.size()), 0);
    ack_if = 1'b1;
    run_until(4, 20, "t4_count");
    chk("t4_d0", 64'(log_q[0].data), 64'h1000_0000);
    chk("t4_d3", 64'(log_q[3].data), 64'h1000_0003);

    // 5: enable low blocks new grants.
    reset_dut();
    enable = 1'b0;
    avail[0] = 2;
    drive();
    repeat (5) tick();
    chk("t5_busy", 64'(busy), 0);
    chk("t5_vld", 64'(vld_out), 0);
    chk("t5_ack", 64'(ack_user), 0);
    chk("t5_dout", 64'(dout), 0);
    enable = 1'b1;
    tick();
    chk("t5_grant", 64'(busy), 1);
    chk("t5_src", 64'(src_id), 0);

    // 6: reset mid-burst of stream 2 (cnt=7); arbitration restarts at stream 0
    // even though stream 3 would be next in round-robin order.
    reset_dut();
    avail[1] = 2;
    avail[2] = 100;
    drive();
    run_until(3, 30, "t6_pre");
    avail[0] = 100;
    avail[3] = 100;
    drive();
    run_until(9, 30, "t6_mid");
    chk("t6_src_mid", 64'(src_id), 2);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_vld", 64'(vld_out), 0);
    chk("t6_dout", 64'(dout), 0);
    chk("t6_ack", 64'(ack_user), 0);
    @(posedge clk);
    #1;
    ap_rst_n = 1'b1;
    log_q.delete();
    run_until(1, 10, "t6_post");
    chk("t6_restart", 64'(log_q[0].src), 0);
    chk("t6_rdata", 64'(log_q[0].data), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
